weight_bank_streamer: RTL and testbench
=======================================

Name: weight_bank_streamer

Overview:
Parametrised multi-bank weight store for the character-recognition datapath; successor to the single-neuron read-only weight RAM.
Holds NUM_BANKS banks of DEPTH weights each, one bank per output neuron. Banks are loadable at run time and can be preloaded from a file.
On a start command, streams one whole bank to the MAC stage over a valid/ready interface, with index and last markers and back-pressure support.

Parameters:
DATA_W, 32, weight word width (IEEE-754 single by default)
DEPTH, 785, words per bank (784 pixels + bias)
NUM_BANKS, 10, number of banks (neurons)
ADDR_W, 10, per-bank address width; must satisfy 2^ADDR_W >= DEPTH
BANK_W, 4, bank index width; must satisfy 2^BANK_W >= NUM_BANKS
INIT_FILE, "", hex file loaded via $readmemh at elaboration if non-empty

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
wr_en  in  1  write strobe
wr_bank  in  BANK_W  bank to write
wr_addr  in  ADDR_W  word within bank
wr_data  in  DATA_W  write data
start  in  1  stream request, sampled in IDLE only
start_bank  in  BANK_W  bank to stream
busy  out  1  high while a stream is in progress
m_valid  out  1  output word valid
m_ready  in  1  consumer ready
m_data  out  DATA_W  weight word
m_index  out  ADDR_W  word index within bank of m_data
m_last  out  1  m_data is word DEPTH-1
err_range  out  1  one-cycle pulse on an out-of-range start or write

Behaviour:
- Storage: flat array of NUM_BANKS*DEPTH words; word address = bank*DEPTH + addr. rst never clears contents.
- Reset values: busy=0, m_valid=0, m_data=0, m_index=0, m_last=0, err_range=0, FSM=IDLE, rd_cnt=0.
- Writes: accepted in any state when wr_en=1, wr_bank<NUM_BANKS and wr_addr<DEPTH; memory updates at the clock edge.
- Invalid writes: a write with an out-of-range bank or address is dropped and err_range pulses for one cycle.
- Same-cycle write and read to one word: read-first; the stream gets the old value.
- FSM states:
  - IDLE: start=1 with start_bank<NUM_BANKS latches base, clears rd_cnt, sets busy=1 and moves to STREAM. start with start_bank>=NUM_BANKS pulses err_range and stays in IDLE. start in any other state is ignored.
  - STREAM: issue condition is (!m_valid || m_ready). On issue, at the next edge: m_data<=mem[base+rd_cnt], m_index<=rd_cnt, m_last<=(rd_cnt==DEPTH-1), m_valid<=1, rd_cnt++. When issuing rd_cnt==DEPTH-1, move to DRAIN.
  - DRAIN: on m_valid && m_ready, clear m_valid and m_last, clear busy, return to IDLE.
- Latency: start accepted at edge N; first m_valid=1 after edge N+1. Throughput is 1 word/cycle when m_ready is held high; a full bank takes DEPTH+1 cycles from start to the last word.
- Back-pressure: while m_valid && !m_ready, m_data, m_index and m_last hold stable and rd_cnt does not advance.
- Handshake: a transfer occurs on any cycle with m_valid && m_ready. Exactly DEPTH transfers per stream, in index order 0..DEPTH-1; m_last is high only on the final one.
- Reset mid-stream: the stream is aborted and all outputs take their reset values after the edge; memory is preserved.
- Simultaneous reset and start: reset wins.

Optional Feature:
WEIGHT_PARITY_EN
- Defined: each word stores an extra even-parity bit, computed on write and on INIT_FILE load. Each streamed word is checked. Adds output parity_err (1 bit, sticky), which is set the cycle after a word with bad parity is presented on m_data. It is cleared only by rst or by a new accepted start.
- Undefined: no parity storage, no parity_err port; behaviour is otherwise identical.

Test Plan:
- Defaults. Write 0x3F800000 to bank 3 at addresses 0..784, start_bank=3, m_ready held high -> 785 transfers on consecutive cycles, m_index 0..784, all data 0x3F800000, m_last only at index 784, busy drops the cycle after the last transfer.
- Write mem[2][k]=k for all k, stream bank 2, m_ready toggling 1,0,0,1 -> data sequence 0..784 with no gaps or duplicates, and m_data stable during every stall.
- start_bank=12 -> err_range pulses once, busy stays 0, no m_valid. Write to wr_addr=800 -> err_range pulses once and memory is unchanged.
- During a bank 0 stream, write bank 0 address 5 = 0xDEADBEEF in the same cycle word 5 is read -> old value streamed. A second stream returns 0xDEADBEEF at index 5.
- Assert rst at word 400 of a stream -> m_valid=0 and busy=0 next cycle. A restart of the same bank streams the full contents intact from index 0.
- With WEIGHT_PARITY_EN, force-flip one stored bit at bank 1 index 10, stream bank 1 -> parity_err rises the cycle after index 10 is presented and stays high until the next start.

Source files
------------

// File: rtl/weight_bank_streamer.sv
// weight_bank_streamer: multi-bank weight store streaming one bank per start over valid/ready.
module weight_bank_streamer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 785,
  parameter int NUM_BANKS = 10,
  parameter int ADDR_W    = 10,
  parameter int BANK_W    = 4,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [BANK_W-1:0] start_bank,
  output logic              busy,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              err_range
`ifdef WEIGHT_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int MEM_D = NUM_BANKS * DEPTH;
  localparam int MEM_W = $clog2(MEM_D);
`ifdef WEIGHT_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t            state, next;
  logic [MW-1:0]     mem [MEM_D];
  logic [MEM_W-1:0]  base, rd_addr, wr_word_addr;
  logic [ADDR_W-1:0] rd_cnt;
  logic [MW-1:0]     wr_word, rd_word;
  logic              wr_ok, start_ok, accept, issue, done, last_rd;

  always_comb begin
    wr_ok        = wr_en && int'(wr_bank) < NUM_BANKS && int'(wr_addr) < DEPTH;
    start_ok     = int'(start_bank) < NUM_BANKS;
    wr_word_addr = MEM_W'(wr_bank) * MEM_W'(DEPTH) + MEM_W'(wr_addr);
`ifdef WEIGHT_PARITY_EN
    wr_word      = {^wr_data, wr_data};
`else
    wr_word      = wr_data;
`endif
    rd_addr      = base + MEM_W'(rd_cnt);
    rd_word      = mem[rd_addr];
    last_rd      = rd_cnt == ADDR_W'(DEPTH - 1);
    accept       = state == IDLE && start && start_ok;
    issue        = state == STREAM && (!m_valid || m_ready);
    done         = state == DRAIN && m_valid && m_ready;
    next         = accept ? STREAM : (issue && last_rd) ? DRAIN : done ? IDLE : state;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_word_addr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_index   <= '0;
      m_last    <= 1'b0;
      err_range <= 1'b0;
      rd_cnt    <= '0;
      base      <= '0;
    end else begin
      state     <= next;
      err_range <= (wr_en && !wr_ok) || (state == IDLE && start && !start_ok);
      if (accept) begin
        base   <= MEM_W'(start_bank) * MEM_W'(DEPTH);
        rd_cnt <= '0;
        busy   <= 1'b1;
      end
      if (issue) begin
        m_data  <= rd_word[DATA_W-1:0];
        m_index <= rd_cnt;
        m_last  <= last_rd;
        m_valid <= 1'b1;
        rd_cnt  <= rd_cnt + 1'b1;
      end
      if (done) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        busy    <= 1'b0;
      end
    end
  end

`ifdef WEIGHT_PARITY_EN
  logic m_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_par      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (issue) m_par <= rd_word[DATA_W];
      parity_err <= accept ? 1'b0 : parity_err | (m_valid && (^m_data != m_par));
    end
  end
`endif

endmodule

// File: tb/tb_weight_bank_streamer.sv
// tb_weight_bank_streamer: scoreboard bench for weight_bank_streamer (default parameters).
module tb_weight_bank_streamer;
    localparam int DATA_W = 32, DEPTH = 785, NUM_BANKS = 10, ADDR_W = 10, BANK_W = 4;
    localparam int MEM_D = NUM_BANKS * DEPTH;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] i;
        logic              l;
    } exp_t;

    logic              clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic [BANK_W-1:0] wr_bank = '0, start_bank = '0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              busy, m_valid, m_last, err_range;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_index;
`ifdef WEIGHT_PARITY_EN
    logic              parity_err;
`endif

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model [MEM_D];
    int                checks = 0, failures = 0, par_idx = -1;

    always #5 clk = ~clk;

    weight_bank_streamer dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_bank(start_bank), .busy(busy),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .err_range(err_range)
`ifdef WEIGHT_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    task automatic fill(input int bank, input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] step);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_bank = BANK_W'(bank);
            wr_addr = ADDR_W'(k);
            wr_data = b + step * DATA_W'(k);
            model[bank*DEPTH+k] = wr_data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Drives start, optional stall pattern, an optional same-cycle write and an optional mid-stream reset.
    task automatic run_stream(input int bank, input bit bp, input int inj,
                              input logic [DATA_W-1:0] inj_d, input int rst_at);
        exp_t              e;
        logic [DATA_W-1:0] sd = '0;
        logic [ADDR_W-1:0] si = '0;
        logic              sl = 1'b0;
        logic [3:0]        pat = 4'b1001;
        bit                stall = 1'b0, seen = 1'b0, hit_rst = 1'b0;
        int                cyc = 0, gaps = 0;
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++)
            exp_q.push_back('{d: model[bank*DEPTH+k], i: ADDR_W'(k), l: (k == DEPTH - 1)});
        if (inj >= 0) model[bank*DEPTH+inj] = inj_d;
        @(negedge clk);
        start = 1'b1; start_bank = BANK_W'(bank); m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_latency bank=%0d busy=%b m_valid=%b expected busy=1 m_valid=0", bank, busy, m_valid);
        end
        while (!hit_rst && exp_q.size() > 0 && cyc < 4 * DEPTH) begin
            m_ready = bp ? pat[cyc%4] : 1'b1;
            wr_en   = (cyc == inj);
            wr_bank = BANK_W'(bank);
            wr_addr = ADDR_W'(inj >= 0 ? inj : 0);
            wr_data = inj_d;
            if (cyc == 1) begin
                checks++;
                if (m_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL first_valid bank=%0d m_valid=%b expected 1", bank, m_valid);
                end
            end
            if (stall) begin
                checks++;
                if ({m_data, m_index, m_last} !== {sd, si, sl}) begin
                    failures++;
                    $display("FAIL stall_hold data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                             m_data, m_index, m_last, sd, si, sl);
                end
            end
            if (seen && !m_valid) gaps++;
            seen  = seen | m_valid;
            stall = m_valid && !m_ready;
            sd = m_data; si = m_index; sl = m_last;
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({m_data, m_index, m_last} !== {e.d, e.i, e.l}) begin
                    failures++;
                    $display("FAIL transfer bank=%0d data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                             bank, m_data, m_index, m_last, e.d, e.i, e.l);
                end
                if (rst_at >= 0 && int'(e.i) == rst_at) begin
                    rst = 1'b1;
                    hit_rst = 1'b1;
                end
            end
`ifdef WEIGHT_PARITY_EN
            if (par_idx >= 0) begin
                checks++;
                if (parity_err !== (cyc >= par_idx + 2)) begin
                    failures++;
                    $display("FAIL parity_err cyc=%0d got=%b expected=%b", cyc, parity_err, cyc >= par_idx + 2);
                end
            end
`endif
            @(negedge clk);
            cyc++;
        end
        wr_en = 1'b0;
        if (hit_rst) begin
            rst = 1'b0;
            checks++;
            if ({busy, m_valid, m_last} !== 3'b000 || m_index !== '0 || m_data !== '0) begin
                failures++;
                $display("FAIL mid_reset busy=%b m_valid=%b last=%b idx=%0d data=%h expected all zero",
                         busy, m_valid, m_last, m_index, m_data);
            end
            exp_q.delete();
        end else begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL stream_timeout bank=%0d remaining=%0d expected 0", bank, exp_q.size());
            end
            checks++;
            if (busy !== 1'b0 || m_valid !== 1'b0) begin
                failures++;
                $display("FAIL busy_drop busy=%b m_valid=%b expected 0 0", busy, m_valid);
            end
            if (!bp) begin
                checks++;
                if (gaps != 0) begin
                    failures++;
                    $display("FAIL gaps bank=%0d got=%0d expected 0", bank, gaps);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start_bank = 4'd2;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, m_valid, m_last, err_range} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags busy=%b m_valid=%b last=%b err=%b expected 0000", busy, m_valid, m_last, err_range);
        end
        checks++;
        if (m_data !== '0 || m_index !== '0) begin
            failures++;
            $display("FAIL reset_data data=%h idx=%0d expected 0 0", m_data, m_index);
        end
        start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_defaults();
        fill(3, 32'h3F80_0000, 32'h0);
        run_stream(3, 1'b0, -1, '0, -1);
    endtask

    task automatic test_backpressure();
        fill(2, 32'h0, 32'h1);
        run_stream(2, 1'b1, -1, '0, -1);
    endtask

    task automatic test_errors();
        fill(0, 32'h100, 32'h3);
        fill(1, 32'h1000_0000, 32'h7);
        @(negedge clk);
        start = 1'b1; start_bank = 4'd12;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err_range !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_start err=%b busy=%b expected 1 0", err_range, busy);
        end
        @(negedge clk);
        checks++;
        if (err_range !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_start_after err=%b busy=%b m_valid=%b expected 0 0 0", err_range, busy, m_valid);
        end
        for (int t = 0; t < 2; t++) begin
            wr_en = 1'b1;
            wr_bank = (t == 0) ? 4'd0 : 4'd10;
            wr_addr = (t == 0) ? 10'd800 : 10'd0;
            wr_data = 32'hBAD0_BAD0;
            @(negedge clk);
            wr_en = 1'b0;
            checks++;
            if (err_range !== 1'b1) begin
                failures++;
                $display("FAIL bad_write%0d err=%b expected 1", t, err_range);
            end
            @(negedge clk);
            checks++;
            if (err_range !== 1'b0) begin
                failures++;
                $display("FAIL bad_write_pulse%0d err=%b expected 0", t, err_range);
            end
        end
    endtask

    task automatic test_read_first();
        run_stream(0, 1'b0, 5, 32'hDEAD_BEEF, -1);
        run_stream(0, 1'b0, -1, '0, -1);
    endtask

    task automatic test_reset_mid();
        run_stream(1, 1'b0, -1, '0, 400);
        run_stream(1, 1'b0, -1, '0, -1);
    endtask

`ifdef WEIGHT_PARITY_EN
    task automatic test_parity();
        dut.mem[DEPTH+10][0] = ~dut.mem[DEPTH+10][0];
        model[DEPTH+10][0] = ~model[DEPTH+10][0];
        par_idx = 10;
        run_stream(1, 1'b0, -1, '0, -1);
        par_idx = -1;
        checks++;
        if (parity_err !== 1'b1) begin
            failures++;
            $display("FAIL parity_sticky got=%b expected 1", parity_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_defaults();
        test_backpressure();
        test_errors();
        test_read_first();
        test_reset_mid();
`ifdef WEIGHT_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
